vresult_tx: RTL
===============

Name: vresult_tx

Overview:
Serial result transmitter; the consuming end of the vdevice result outputs.
- On a send request it snapshots the three 8-bit counter values.
- It transmits a header byte followed by the three counters as UART-style 8N1 frames on a single tx line.
- It sits between vdevice (counter_2/1/0, valid in TIMEOUT) and the board's serial pin.
- It runs at a fixed, parameterised bit period.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 2.
- HEADER, 8'hA5, sync byte sent before the counter bytes.

Ports:
- clk  in  1  system clock
- async_nreset  in  1  asynchronous active-low reset
- send  in  1  transmit request; sampled only in IDLE
- counter_2  in  8  first counter byte (sent 2nd)
- counter_1  in  8  second counter byte (sent 3rd)
- counter_0  in  8  third counter byte (sent 4th)
- tx  out  1  serial line, idle high, registered
- busy  out  1  high while a message is in flight, registered
- done  out  1  one-cycle pulse when the message completes, registered

Behaviour:
- Reset is async_nreset, asynchronous, active-low; clock is clk.
- During reset, and at any reset mid-message: tx=1, busy=0, done=0, state=IDLE, all counters=0. An interrupted message is abandoned and produces no done pulse.
- Message format: 4 frames back-to-back with no idle gap, sent in the order HEADER, counter_2, counter_1, counter_0.
- Frame format: 1 start bit (0), then 8 data bits LSB-first, then 1 stop bit (1). Every bit is held exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
- IDLE, send=1 at edge N:
  - Load the 4-byte buffer from HEADER and the counter inputs.
  - State -> START, tx -> 0, busy -> 1 (all visible after edge N).
  - Clear the baud counter, bit index and byte index.
- IDLE, send=0: hold, tx=1.
- START: after CLKS_PER_BIT cycles -> DATA, tx = current byte bit 0.
- DATA: every CLKS_PER_BIT cycles, advance the bit index (3 bits). After bit 7's period -> STOP, tx=1.
- STOP, after CLKS_PER_BIT cycles:
  - If byte index < 3: increment the byte index, -> START, tx=0.
  - Otherwise: -> IDLE, busy -> 0, done -> 1 for exactly one cycle.
- Timing: total message = 40*CLKS_PER_BIT cycles. busy is high from edge N+1 through edge N+40*CLKS_PER_BIT; done is asserted for the single cycle after edge N+40*CLKS_PER_BIT.
- send while busy is ignored; the request is neither queued nor restarted.
- send in the same cycle as the done pulse: state is already IDLE, so the request is accepted and the next message starts at the following edge.
- Counter inputs changing mid-message have no effect; only the snapshot is sent.
- Baud counter width is $clog2(CLKS_PER_BIT). It wraps from CLKS_PER_BIT-1 to 0, and that wrap is the bit tick. It runs only while busy.
- tx is driven only from a flop; no combinational path from any input to tx.

Decomposition:
- Shared package vresult_tx_pkg holds:
  - state encodings (2 bits: IDLE=0, START=1, DATA=2, STOP=3);
  - DATA_BITS=8;
  - FRAME_COUNT=4;
  - the TX_IDLE level = 1.
- One sub-module, vbaud_tick: a parameterised counter with enable and clear inputs, emitting a one-cycle tick at terminal count CLKS_PER_BIT-1. Its enable/clear interface matches the timer style used by vdevice.

Test Plan:
1. Reset then idle for 100 cycles: tx=1, busy=0, done=0 throughout.
2. CLKS_PER_BIT=4; counter_2=8'h03, counter_1=8'h0A, counter_0=8'hFF; send pulse at edge N:
   - tx at bit centres = 0,1,0,1,0,0,1,0,1,1 | 0,1,1,0,0,0,0,0,0,1 | 0,0,1,0,1,0,0,0,0,1 | 0,1,1,1,1,1,1,1,1,1;
   - done pulses once, on the cycle after edge N+160; busy falls at that same edge.
3. Re-assert send 20 cycles into a message: the waveform is identical to scenario 2 and exactly one done pulse occurs.
4. Change all counters to 8'h00 at cycle 30 of a message: the transmitted bytes still equal the snapshot values from send time.
5. Hold send high continuously with CLKS_PER_BIT=4: messages repeat every 161 cycles (160 cycles of message plus 1 IDLE/done cycle), with no gap and no extra start bit.
6. Pulse async_nreset low during the 2nd DATA frame: tx=1 and busy=0 immediately with no done pulse. A subsequent send produces a full, correct message.

Source files
------------

// File: rtl/vresult_tx_pkg.sv
// Shared definitions for the serial result transmitter: FSM encoding,
// frame geometry and the idle level of the serial line.
package vresult_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam int   FRAME_COUNT = 4;
  localparam logic TX_IDLE     = 1'b1;

endpackage

// File: rtl/vbaud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and emits a
// one-cycle tick on the terminal count, wrapping back to zero.
// clr has priority over en and holds the count at zero.
module vbaud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == TERMINAL);

  // Free-running period counter, cleared on request, wrapping at terminal count
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vresult_tx.sv
// Serial result transmitter. On send (while idle) it snapshots a header byte
// and three counter bytes, then shifts them out as back-to-back 8N1 frames
// on tx. busy covers the whole message; done pulses once when it completes.
//
// Handshake: send is a level request sampled only when idle; there is no
// ready/ack other than busy rising on the next cycle, and requests made
// while busy are dropped, not queued.
module vresult_tx
  import vresult_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic       send,
  input  logic [7:0] counter_2,
  input  logic [7:0] counter_1,
  input  logic [7:0] counter_0,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BYTE_W = $clog2(FRAME_COUNT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  tx_state_t                            state;
  logic [FRAME_COUNT-1:0][DATA_BITS-1:0] msg_buf;
  logic [BIT_W-1:0]                     bit_idx;
  logic [BYTE_W-1:0]                    byte_idx;
  logic [BIT_W-1:0]                     next_bit;
  logic                                 bit_tick;
  logic                                 baud_clr;

  // The timer is held at zero while idle so each message starts on a fresh period
  assign baud_clr = (state == IDLE);
  assign next_bit = bit_idx + BIT_W'(1);

  vbaud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk          (clk),
    .async_nreset (async_nreset),
    .en           (busy),
    .clr          (baud_clr),
    .tick         (bit_tick)
  );

  // Message FSM; tx, busy and done are all registered here
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state    <= IDLE;
      msg_buf  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx       <= TX_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= TX_IDLE;
          if (send) begin
            // Frame order on the wire: index 0 first
            msg_buf  <= {counter_0, counter_1, counter_2, HEADER};
            bit_idx  <= '0;
            byte_idx <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            tx    <= msg_buf[byte_idx][0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            bit_idx <= next_bit;
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx <= msg_buf[byte_idx][next_bit];
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (byte_idx != BYTE_W'(FRAME_COUNT - 1)) begin
              byte_idx <= byte_idx + BYTE_W'(1);
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= TX_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= TX_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
